addsub32_seq: RTL and testbench

ADDSUB32_SEQ -- requirements
Module: addsub32_seq

---
 rtl/addsub32_seq.sv | 205 ++++++++++++++++++++
 tb/tb_addsub32_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub32_seq.sv
// addsub32_seq -- 32-bit add/subtract unit built around one 16-bit
// parallel-prefix (Kogge-Stone) adder that is time-shared over the low and
// high halves. One operand beat is accepted, the low half is summed in LO,
// the high half (plus flags) in HI, and the result is held in DONE until the
// consumer takes it.
//
// Configuration macro: ADDSUB32_SEQ_FLAGS_EN
//   defined   -> flags = {carry, overflow, zero, negative}
//   undefined -> flags tied to 4'b0000 (port kept, sum/timing unchanged)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat offered
//   in_ready   out  operand beat accepted this cycle (with in_valid)
//   op         in   0 = add, 1 = subtract
//   cin        in   carry-in for add (ignored for subtract)
//   a, b       in   operands
//   out_valid  out  result beat held
//   out_ready  in   consumer takes result
//   sum        out  result
//   flags      out  {carry, overflow, zero, negative}

// 16-bit Kogge-Stone adder with carry-in and carry-out.
module addsub32_seq_pfx16 (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);

    logic [15:0] w_g0, w_p0;
    logic [15:0] w_g1, w_p1;
    logic [15:0] w_g2, w_p2;
    logic [15:0] w_g3, w_p3;
    logic [15:0] w_g4, w_p4;
    logic [16:0] w_c;

    assign w_g0 = i_x & i_y;
    assign w_p0 = i_x ^ i_y;

    // Each level combines spans at distance 1, 2, 4, 8. Shifting in 0 for
    // generate and 1 for propagate leaves the low bits of a level unchanged.
    assign w_g1 = w_g0 | (w_p0 & {w_g0[14:0], 1'b0});
    assign w_p1 = w_p0 & {w_p0[14:0], 1'b1};
    assign w_g2 = w_g1 | (w_p1 & {w_g1[13:0], 2'b00});
    assign w_p2 = w_p1 & {w_p1[13:0], 2'b11};
    assign w_g3 = w_g2 | (w_p2 & {w_g2[11:0], 4'h0});
    assign w_p3 = w_p2 & {w_p2[11:0], 4'hF};
    assign w_g4 = w_g3 | (w_p3 & {w_g3[7:0], 8'h00});
    assign w_p4 = w_p3 & {w_p3[7:0], 8'hFF};

    // w_c[i] is the carry into bit i; carry-in folds in through the group
    // propagate of bits [i-1:0].
    assign w_c    = {w_g4 | (w_p4 & {16{i_cin}}), i_cin};
    assign o_sum  = w_p0 ^ w_c[15:0];
    assign o_cout = w_c[16];

endmodule

module addsub32_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);

    localparam int unsigned HALF = WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;      // b', already inverted for subtract
    logic              r_op;
    logic              r_cin;
    logic              r_c16;
    logic [WIDTH-1:0]  r_sum;

    logic              w_accept;
    logic [HALF-1:0]   w_x;
    logic [HALF-1:0]   w_y;
    logic              w_ci;
    logic [HALF-1:0]   w_s;
    logic              w_co;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_LO;
            S_LO:   w_next = S_HI;
            S_HI:   w_next = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_next = w_accept ? S_LO : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Adder operand select: low half in LO (carry-in = 1 for subtract, else
    // cin), high half in HI with the registered carry out of the low half.
    always_comb begin
        w_x  = r_a[HALF-1:0];
        w_y  = r_b[HALF-1:0];
        w_ci = r_op | r_cin;
        if (r_state == S_HI) begin
            w_x  = r_a[WIDTH-1:HALF];
            w_y  = r_b[WIDTH-1:HALF];
            w_ci = r_c16;
        end
    end

    addsub32_seq_pfx16 u_pfx (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_cin  (w_ci),
        .o_sum  (w_s),
        .o_cout (w_co)
    );

    // Accept (IDLE/DONE) never coincides with LO/HI, so the result halves are
    // only rewritten after out_valid has dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= 1'b0;
            r_cin <= 1'b0;
            r_c16 <= 1'b0;
            r_sum <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= op ? ~b : b;
                r_op  <= op;
                r_cin <= cin;
            end
            if (r_state == S_LO) begin
                r_sum[HALF-1:0] <= w_s;
                r_c16           <= w_co;
            end
            if (r_state == S_HI) begin
                r_sum[WIDTH-1:HALF] <= w_s;
            end
        end
    end

`ifdef ADDSUB32_SEQ_FLAGS_EN
    logic [3:0]       r_flags;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    // Flags are formed in HI from the fresh upper half and the stored lower half.
    always_comb begin
        w_res = {w_s, r_sum[HALF-1:0]};
        w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (r_state == S_HI) begin
            r_flags <= {w_co, w_ovf, (w_res == '0), w_res[WIDTH-1]};
        end
    end

    assign flags = r_flags;
`else
    assign flags = '0;
`endif

endmodule

// File: tb/tb_addsub32_seq.sv
// Testbench for addsub32_seq: directed vectors, scoreboard queue filled by the
// driver on accept, drained by an independent monitor on each result handshake.
// Expected flags follow the ADDSUB32_SEQ_FLAGS_EN build setting.
module tb_addsub32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic [3:0]  flags;

    addsub32_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int last_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] s;
        logic [3:0]  f;
        int          acc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic        cin;
        logic [31:0] s;
        logic [3:0]  f;
    } vec_t;

    vec_t vt[0:6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ef(input logic [3:0] f);
`ifdef ADDSUB32_SEQ_FLAGS_EN
        return f;
`else
        return 4'b0000;
`endif
    endfunction

    // Offer one beat; push the expected result at the accepting edge.
    task automatic send(input vec_t v);
        int   n;
        bit   done;
        exp_t e;
        a = v.a; b = v.b; op = v.op; cin = v.cin; in_valid = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.s = v.s; e.f = ef(v.f); e.acc = cyc + 1;
                sb.push_back(e);
                last_acc = cyc + 1;
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    checks++; errors++;
                    $display("FAIL accept_timeout in_ready=%0b after %0d cycles", in_ready, n);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency on out_valid rise, stability while stalled, value on handshake.
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    if (!prev_v) begin
                        checks++; errors++;
                        $display("FAIL spurious_out_valid got=1 exp=0 sum=0x%08h", sum);
                    end
                end else begin
                    if (!prev_v) chk("latency", 32'(cyc - sb[0].acc), 32'd2);
                    if (!out_ready) begin
                        chk("stall_in_ready", 32'(in_ready), 32'd0);
                        chk("stall_sum", sum, sb[0].s);
                        chk("stall_flags", 32'(flags), 32'(sb[0].f));
                    end else begin
                        chk("sum", sum, sb[0].s);
                        chk("flags", 32'(flags), 32'(sb[0].f));
                        last_hs = cyc + 1;
                        void'(sb.pop_front());
                    end
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_acc;

        //          a             b             op    cin   sum           {c,v,z,n}
        vt[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 4'b0000};
        vt[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 4'b1010};
        vt[2] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 4'b1100};
        vt[3] = '{32'h00000003, 32'h00000005, 1'b1, 1'b0, 32'hFFFFFFFE, 4'b0001};
        vt[4] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 32'hACF13569, 4'b0001};
        vt[5] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 4'b1010};
        vt[6] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 4'b0101};

        // Reset values
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Isolated transactions
        for (int unsigned i = 0; i < 7; i++) begin
            send(vt[i]);
            drain();
        end

        // Back-to-back: one accept every 3 cycles
        prev_acc = 0;
        for (int unsigned i = 0; i < 7; i++) begin
            send(vt[i]);
            if (i != 0) chk("throughput", 32'(last_acc - prev_acc), 32'd3);
            prev_acc = last_acc;
        end
        drain();

        // Backpressure: hold 5 cycles in DONE with a pending beat, then release
        out_ready = 1'b0;
        send(vt[2]);
        fork
            begin
                int n;
                n = 0;
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            send(vt[3]);
        join
        chk("same_cycle_accept", 32'(last_acc), 32'(last_hs));
        drain();

        // Reset during HI discards the operation
        sb.delete();
        send(vt[4]);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", sum, 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        #6;
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_result_after_reset", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Recovery after reset
        send(vt[6]);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
